div_radix2_param: RTL and testbench

- Parametrised, multi-cycle radix-2 restoring integer divider for the EXE stage; successor to the fixed 32-bit divider.
- Adds a configurable width, latched operands, and separate quotient/remainder outputs.
- Adds explicit divide-by-zero reporting, an optional leading-zero skip, a busy flag and a one-cycle done pulse.
- The EXE stage stalls on busy_o and writes HI/LO on done_o.

---
 rtl/div_radix2_param.sv | 203 ++++++++++++++++++++
 tb/tb_div_radix2_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix2_param.sv
// Multi-cycle radix-2 restoring divider with configurable width, optional leading-zero skip,
// divide-by-zero reporting, annul and a one-cycle done pulse. Results hold until the next completion.
module div_radix2_param #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_SKIP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             start_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    part_q, part_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdiv_q, sdiv_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] mag1, mag2, dvd_norm;
    logic [CW-1:0]    sig_bits, iter_n;
    logic             trial_neg;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] q_raw, r_raw;

    assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !annul_i;
    assign last_iter = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = (opdata2_i == '0) ? S_FIXUP : S_CALC;
                end
            end
            S_CALC: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else if (last_iter) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: state_d = annul_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == S_CALC) || (state_q == S_FIXUP);
        done_o = done_q;
        div0_o = div0_q;
        quot_o = quot_q;
        rem_o  = rem_q;
    end

    // Operand magnitudes and, with EARLY_SKIP, the dividend normalised so its MSB leads.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        sig_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag1[i]) begin
                sig_bits = CW'(i + 1);
            end
        end
        if (!EARLY_SKIP) begin
            iter_n = CW'(WIDTH);
        end else if (sig_bits == '0) begin
            iter_n = CW'(1);
        end else begin
            iter_n = sig_bits;
        end
        dvd_norm = mag1 << (CW'(WIDTH) - iter_n);
    end

    // Trial subtraction on the upper WIDTH+1 bits; a non-negative result always fits in WIDTH bits.
    always_comb begin
        trial_neg = (part_q[PW-1:WIDTH] < {1'b0, dvsr_q});
        trial     = part_q[PW-2:WIDTH] - dvsr_q;
        q_raw     = part_q[WIDTH-1:0];
        r_raw     = part_q[PW-1:WIDTH+1];
    end

    always_comb begin
        part_d  = part_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        sdiv_d  = sdiv_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        zdiv_d  = zdiv_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    sdiv_d  = signed_div_i;
                    sign1_d = opdata1_i[WIDTH-1];
                    sign2_d = opdata2_i[WIDTH-1];
                    dvsr_d  = mag2;
                    cnt_d   = iter_n;
                    zdiv_d  = (opdata2_i == '0);
                    // A zero divisor parks the raw dividend where the remainder is read out.
                    if (opdata2_i == '0) begin
                        part_d = {opdata1_i, {(WIDTH + 1){1'b0}}};
                    end else begin
                        part_d = {{WIDTH{1'b0}}, dvd_norm, 1'b0};
                    end
                end
            end
            S_CALC: begin
                if (!annul_i) begin
                    cnt_d = cnt_q - CW'(1);
                    if (trial_neg) begin
                        part_d = {part_q[PW-2:0], 1'b0};
                    end else begin
                        part_d = {trial, part_q[WIDTH-1:0], 1'b1};
                    end
                end
            end
            S_FIXUP: begin
                if (!annul_i) begin
                    done_d = 1'b1;
                    div0_d = zdiv_q;
                    if (zdiv_q) begin
                        quot_d = '1;
                        rem_d  = r_raw;
                    end else begin
                        quot_d = (sdiv_q && (sign1_q ^ sign2_q)) ? -q_raw : q_raw;
                        rem_d  = (sdiv_q && sign1_q) ? -r_raw : r_raw;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            sdiv_q  <= 1'b0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            zdiv_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            part_q  <= part_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            sdiv_q  <= sdiv_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            zdiv_q  <= zdiv_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_div_radix2_param.sv
// Bench for div_radix2_param: fixed-latency and early-skip instances share stimulus and are
// checked every cycle against an arithmetic model, plus literal expectations per directed vector.
module tb_div_radix2_param;

    localparam int W = 32;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         signed_div = 1'b0;
    logic [W-1:0] op1        = '0;
    logic [W-1:0] op2        = '0;
    logic         start      = 1'b0;
    logic         annul      = 1'b0;

    logic         busy0, done0, div00;
    logic         busy1, done1, div01;
    logic [W-1:0] quot0, rem0, quot1, rem1;

    int n_checks = 0;
    int n_fail   = 0;

    div_radix2_param #(.WIDTH(W), .EARLY_SKIP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .busy_o(busy0), .done_o(done0), .div0_o(div00),
        .quot_o(quot0), .rem_o(rem0)
    );

    div_radix2_param #(.WIDTH(W), .EARLY_SKIP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .busy_o(busy1), .done_o(done1), .div0_o(div01),
        .quot_o(quot1), .rem_o(rem1)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int           cyc = 0;
    logic         m_busy [2];
    logic         m_done [2];
    logic         m_d0   [2];
    logic [W-1:0] m_q    [2];
    logic [W-1:0] m_r    [2];
    int           m_due  [2];
    logic [2*W:0] exp_q0[$];
    logic [2*W:0] exp_q1[$];

    function automatic logic [2*W:0] model_div(logic sgn, logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb, q64, r64;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (!sgn) return {1'b0, a / b, a % b};
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        q64 = sa / sb;
        r64 = sa % sb;
        return {1'b0, q64[W-1:0], r64[W-1:0]};
    endfunction

    function automatic int model_lat(bit es, logic sgn, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] m;
        int           n;
        if (b == '0) return 1;
        if (!es) return W + 1;
        m = (sgn && a[W-1]) ? -a : a;
        n = 0;
        while (m != '0) begin
            m = m >> 1;
            n++;
        end
        return ((n < 1) ? 1 : n) + 1;
    endfunction

    function automatic logic [2*W:0] pop_exp(int k);
        logic [2*W:0] v = '0;
        if (k == 0) begin
            if (exp_q0.size() > 0) v = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) v = exp_q1.pop_front();
        end
        return v;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_d0[k]   = 1'b0;
            m_q[k]    = '0;
            m_r[k]    = '0;
            m_due[k]  = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    m_done[k] = 1'b0;
                    if (m_busy[k]) begin
                        if (annul) begin
                            m_busy[k] = 1'b0;
                            void'(pop_exp(k));
                        end else if (cyc == m_due[k]) begin
                            m_busy[k] = 1'b0;
                            m_done[k] = 1'b1;
                            {m_d0[k], m_q[k], m_r[k]} = pop_exp(k);
                        end
                    end else if (start && !annul) begin
                        if (k == 0) exp_q0.push_back(model_div(signed_div, op1, op2));
                        else        exp_q1.push_back(model_div(signed_div, op1, op2));
                        m_due[k]  = cyc + model_lat(k == 1, signed_div, op1, op2);
                        m_busy[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(int k, logic b, logic d, logic z, logic [W-1:0] q, logic [W-1:0] r);
        n_checks++;
        if ({b, d, z, q, r} !== {m_busy[k], m_done[k], m_d0[k], m_q[k], m_r[k]}) begin
            n_fail++;
            $display("FAIL model_cmp dut%0d cyc=%0d got busy=%b done=%b div0=%b q=%h r=%h exp busy=%b done=%b div0=%b q=%h r=%h",
                     k, cyc, b, d, z, q, r, m_busy[k], m_done[k], m_d0[k], m_q[k], m_r[k]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, busy0, done0, div00, quot0, rem0);
            cmp(1, busy1, done1, div01, quot1, rem1);
        end
    end

    // ---------------- literal checks and drivers ----------------
    task automatic chk(string name, logic [95:0] got, logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Entered just after a rising edge; accept happens at the next edge.
    task automatic do_op(string name, logic sgn, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] eq, logic [W-1:0] er, logic ed0,
                         int el0, int el1, bit hold);
        int g0 = -1;
        int g1 = -1;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        op1        = $urandom;
        op2        = $urandom_range(1, 1000);
        signed_div = 1'($urandom_range(0, 1));
        for (int e = 1; e <= 60 && (g0 < 0 || g1 < 0); e++) begin
            @(posedge clk);
            #1;
            if (done0 && g0 < 0) begin
                g0 = e;
                chk({name, "_res0"}, {busy0, div00, quot0, rem0}, {1'b0, ed0, eq, er});
            end
            if (done1 && g1 < 0) begin
                g1 = e;
                chk({name, "_res1"}, {busy1, div01, quot1, rem1}, {1'b0, ed0, eq, er});
            end
            if (g0 >= 0 && g1 >= 0) start = 1'b0;
        end
        start = 1'b0;
        chk_int({name, "_lat0"}, g0, el0);
        chk_int({name, "_lat1"}, g1, el1);
    endtask

    task automatic annul_test();
        logic seen = 1'b0;
        signed_div = 1'b0;
        op1        = 32'h8765_4321;
        op2        = 32'h0000_0123;
        start      = 1'b1;
        annul      = 1'b1;
        @(posedge clk);
        #1;
        chk("start_with_annul_no_accept", {busy0, busy1}, 2'b00);
        annul = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("annul_busy_before", {busy0, busy1}, 2'b11);
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul_after0", {busy0, done0, div00, quot0, rem0}, {3'b000, 32'h2249_2492, 32'd2});
        chk("annul_after1", {busy1, done1, div01, quot1, rem1}, {3'b000, 32'h2249_2492, 32'd2});
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done0 || done1 || busy0 || busy1) seen = 1'b1;
        end
        chk("annul_no_done_later", seen, 1'b0);
    endtask

    task automatic reset_test();
        signed_div = 1'b0;
        op1        = 32'h1234_5678;
        op2        = 32'h0000_0011;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst0", {busy0, done0, div00, quot0, rem0}, '0);
        chk("async_rst1", {busy1, done1, div01, quot1, rem1}, '0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_idle", {busy0, busy1, done0, done1}, 4'b0000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state0", {busy0, done0, div00, quot0, rem0}, '0);
        chk("reset_state1", {busy1, done1, div01, quot1, rem1}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op("u100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 8,  1'b0);
        do_op("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33, 4,  1'b0);
        do_op("s_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33, 4,  1'b0);
        do_op("u_fff9_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 33, 33, 1'b0);
        do_op("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33, 33, 1'b0);
        do_op("u_ovf_ops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33, 33, 1'b0);
        do_op("s_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33, 8,  1'b0);
        do_op("u5_0",       1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  1,  1'b0);
        do_op("u9_3_done",  1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33, 5,  1'b0);
        do_op("s_m1_0",     1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1,  1,  1'b0);
        do_op("u5_3",       1'b0, 32'd5,          32'd3,          32'd1,          32'd2,          1'b0, 33, 4,  1'b0);
        do_op("u0_7",       1'b0, 32'd0,          32'd7,          32'd0,          32'd0,          1'b0, 33, 2,  1'b0);
        do_op("u_ffff_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33, 33, 1'b0);
        do_op("hold_start", 1'b0, 32'hF000_0000,  32'd7,          32'h2249_2492,  32'd2,          1'b0, 33, 33, 1'b1);
        annul_test();
        reset_test();
        do_op("u1000_10",   1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 33, 11, 1'b0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
